vga_sync_controller: RTL and testbench
======================================

VGA_SYNC_CONTROLLER -- requirements
Module: vga_sync_controller

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Clock and reset: one clock, CLK100MHZ; reset RESET is synchronous and active-high.
REQ-010 CLK100MHZ  input  1  system clock, 100 MHz; the only clock, all logic on rising edge.
REQ-011 RESET  input  1  synchronous active-high reset.
REQ-012 ENABLE  input  1  request to run video timing; level-sensitive.
REQ-013 PIXEL_TICK  output  1  one-cycle pulse every 4th CLK100MHZ cycle (25 MHz pixel rate).
REQ-014 HSYNC  output  1  horizontal sync.
REQ-015 VSYNC  output  1  vertical sync.
REQ-016 VIDEO_ON  output  1  high while X < H_ACTIVE and Y < V_ACTIVE and state RUN/STOPPING.
REQ-017 X  output  10  current pixel column.
REQ-018 Y  output  10  current line.
REQ-019 FRAME_START  output  1  one-cycle pulse coincident with PIXEL_TICK when X=0, Y=0 in RUN/STOPPING.
REQ-020 ACTIVE  output  1  high in RUN or STOPPING.

Function
REQ-021 The block SHALL contain a 2-bit free-running divide counter, PIXEL_TICK high when it equals 3; counter wraps 3->0.
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); X, Y SHALL change only on PIXEL_TICK cycles.
REQ-023 On PIXEL_TICK in RUN/STOPPING: X increments; X=H_TOTAL-1 wraps to 0 and Y increments; Y=V_TOTAL-1 with X wrap wraps Y to 0.
REQ-024 HSYNC asserted for H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC; VSYNC for V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC.
REQ-025 HSYNC, VSYNC, VIDEO_ON SHALL be registered and valid in the same cycle as the X/Y values they decode.
REQ-026 FSM states IDLE, RUN, STOPPING; IDLE->RUN on the cycle after ENABLE sampled high.
REQ-027 RUN->STOPPING when ENABLE sampled low; STOPPING->RUN if ENABLE sampled high again, timing uninterrupted.
REQ-028 STOPPING->IDLE on the PIXEL_TICK with X=H_TOTAL-1, Y=V_TOTAL-1; frames are never truncated.
REQ-029 In IDLE: X=0, Y=0, VIDEO_ON=0, FRAME_START=0, syncs inactive; divide counter and PIXEL_TICK keep running.
REQ-030 First PIXEL_TICK in RUN SHALL present X=0, Y=0 and FRAME_START=1.
REQ-031 Simultaneous frame-end tick and ENABLE high in STOPPING SHALL go to RUN and wrap to X=0, Y=0 with FRAME_START.

Reset
REQ-032 RESET high at a rising edge SHALL force: divide counter 0, PIXEL_TICK 0, state IDLE, X=0, Y=0, VIDEO_ON 0, FRAME_START 0, ACTIVE 0, syncs inactive.
REQ-033 Reset mid-frame SHALL abort immediately; no drain to frame end.
REQ-034 After RESET falls, first PIXEL_TICK SHALL occur on the 4th rising edge.

Configuration
REQ-035 Macro VGA_SYNC_ACTIVE_LOW_EN defined: HSYNC/VSYNC are active-low (idle 1, pulse 0), per industry 640x480@60.
REQ-036 Macro undefined: HSYNC/VSYNC are active-high (idle 0, pulse 1); all other behaviour identical.

Verification
REQ-037 Reset, release, ENABLE=1 -> PIXEL_TICK period exactly 4 cycles; first RUN tick X=0,Y=0,FRAME_START=1.
REQ-038 Run one line -> HSYNC active exactly for X=656..751 (96 ticks); X wraps 799->0, Y 0->1.
REQ-039 Run full frame -> VSYNC active for Y=490..491; VIDEO_ON count 307200 ticks; next FRAME_START 420000 ticks later.
REQ-040 Drop ENABLE at X=100,Y=200 -> ACTIVE stays 1 to X=799,Y=524 tick, then IDLE, X=Y=0, syncs inactive.
REQ-041 Drop ENABLE then re-raise before frame end -> no IDLE entry, X/Y sequence continuous.
REQ-042 Assert RESET at X=300,Y=100 -> next cycle all outputs at reset values, both macro settings checked for sync polarity.

Source files
------------

// File: rtl/vga_sync_controller.sv
// ---------------------------------------------------------------------------
// vga_sync_controller
//
// Purpose:
//   Generates VGA raster timing (640x480@60 by default) from a 100 MHz clock.
//   A free-running /4 divider produces the 25 MHz pixel tick. A three-state
//   controller (IDLE/RUN/STOPPING) gates the raster counters so that a
//   stop request always lets the current frame finish.
//
// Configuration macro:
//   VGA_SYNC_ACTIVE_LOW_EN  defined   -> HSYNC/VSYNC active-low (idle 1)
//                           undefined -> HSYNC/VSYNC active-high (idle 0)
//
// Ports:
//   CLK100MHZ    in   system clock, all logic on rising edge
//   RESET        in   synchronous active-high reset
//   ENABLE       in   level request to run the video timing
//   PIXEL_TICK   out  one-cycle pulse every 4th clock
//   HSYNC        out  horizontal sync (polarity set by macro)
//   VSYNC        out  vertical sync (polarity set by macro)
//   VIDEO_ON     out  current X/Y lies in the visible area while running
//   X, Y         out  current pixel column / line (10 bits each)
//   FRAME_START  out  pulse on the tick presenting X=0, Y=0 while running
//   ACTIVE       out  controller is in RUN or STOPPING
// ---------------------------------------------------------------------------
module vga_sync_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic       ENABLE,
  output logic       PIXEL_TICK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       VIDEO_ON,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       FRAME_START,
  output logic       ACTIVE
);

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif
  localparam logic SYNC_OFF = !SYNC_ON;

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  logic [1:0] div;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       tick;
  logic       running;
  logic       running_nxt;
  logic       frame_end;

  assign tick        = (div == 2'd3);
  assign running     = (state != ST_IDLE);
  assign running_nxt = (state_nxt != ST_IDLE);
  assign frame_end   = tick && running && (X == H_LAST) && (Y == V_LAST);

  assign PIXEL_TICK  = tick;
  assign ACTIVE      = running;
  assign FRAME_START = tick && running && (X == 10'd0) && (Y == 10'd0);

  // Next state and next raster position. A re-raised ENABLE in STOPPING
  // takes priority over the frame-end drain, so a tick that ends the frame
  // simply wraps into a new one. Whenever the controller lands in IDLE the
  // raster is parked at 0,0 so the first RUN tick presents the frame origin.
  always_comb begin
    state_nxt = state;
    x_nxt     = X;
    y_nxt     = Y;

    case (state)
      ST_IDLE:     if (ENABLE) state_nxt = ST_RUN;
      ST_RUN:      if (!ENABLE) state_nxt = ST_STOPPING;
      ST_STOPPING: begin
        if (ENABLE)         state_nxt = ST_RUN;
        else if (frame_end) state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase

    if (running && tick) begin
      if (X == H_LAST) begin
        x_nxt = 10'd0;
        y_nxt = (Y == V_LAST) ? 10'd0 : Y + 10'd1;
      end else begin
        x_nxt = X + 10'd1;
      end
    end

    if (!running_nxt) begin
      x_nxt = 10'd0;
      y_nxt = 10'd0;
    end
  end

  // The sync and blanking flags are decoded from the next position so that
  // their registered values line up with the X/Y registers they describe.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      div      <= 2'd0;
      state    <= ST_IDLE;
      X        <= 10'd0;
      Y        <= 10'd0;
      HSYNC    <= SYNC_OFF;
      VSYNC    <= SYNC_OFF;
      VIDEO_ON <= 1'b0;
    end else begin
      div      <= div + 2'd1;
      state    <= state_nxt;
      X        <= x_nxt;
      Y        <= y_nxt;
      HSYNC    <= (running_nxt && x_nxt >= HS_START && x_nxt < HS_END) ? SYNC_ON : SYNC_OFF;
      VSYNC    <= (running_nxt && y_nxt >= VS_START && y_nxt < VS_END) ? SYNC_ON : SYNC_OFF;
      VIDEO_ON <= running_nxt && (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_sync_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_controller
//
// Purpose:
//   Self-checking bench for vga_sync_controller. The DUT runs with a shrunken
//   raster (18 x 11 total, 10 x 6 visible) so whole frames fit in a short
//   run. The stimulus process steps a small reference model each clock and
//   pushes the expected outputs for every pixel-tick cycle into a scoreboard;
//   an independent monitor pops and compares whenever PIXEL_TICK is high.
//   Honours VGA_SYNC_ACTIVE_LOW_EN for the expected sync polarity.
//
// Shrunken raster:
//   H: active 10, fp 2, sync 3, bp 3  -> total 18, HSYNC for X = 12..14
//   V: active 6,  fp 1, sync 2, bp 2  -> total 11, VSYNC for Y = 7..8
//   one frame = 198 ticks, 60 visible ticks, 33 HSYNC ticks, 36 VSYNC ticks
// ---------------------------------------------------------------------------
module tb_vga_sync_controller;

  localparam int HA = 10, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = 18;
  localparam int VT = 11;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic ON = 1'b0;
`else
  localparam logic ON = 1'b1;
`endif
  localparam logic OFF = !ON;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic       act;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t obs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       pixel_tick, hsync, vsync, video_on, frame_start, active;
  logic [9:0] x, y;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];

  // reference model state
  int m_div = 0;
  int m_st  = 0;
  int mx    = 0;
  int my    = 0;

  // monitor statistics for the first complete frame
  int tick_cnt = 0, fs_tick = 0, frame_len = 0;
  int acc_von = 0, acc_hs = 0, acc_vs = 0;
  int f_von = 0, f_hs = 0, f_vs = 0;
  bit fs_seen = 0, frame_done = 0;
  exp_t head;
  obs_t got;

  vga_sync_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .CLK100MHZ  (clk),
    .RESET      (rst),
    .ENABLE     (en),
    .PIXEL_TICK (pixel_tick),
    .HSYNC      (hsync),
    .VSYNC      (vsync),
    .VIDEO_ON   (video_on),
    .X          (x),
    .Y          (y),
    .FRAME_START(frame_start),
    .ACTIVE     (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the model's current cycle.
  function automatic obs_t modelObs();
    obs_t o;
    logic a;
    a     = (m_st != 0);
    o.x   = 10'(mx);
    o.y   = 10'(my);
    o.act = a;
    o.hs  = (a && mx >= HA + HF && mx < HA + HF + HS) ? ON : OFF;
    o.vs  = (a && my >= VA + VF && my < VA + VF + VS) ? ON : OFF;
    o.von = a && mx < HA && my < VA;
    o.fs  = a && mx == 0 && my == 0 && m_div == 3;
    return o;
  endfunction

  // One clock: advance the model with the inputs seen at this edge, then
  // queue the expectation if the new cycle carries a pixel tick.
  task automatic stepCycle();
    int   nst;
    bit   tk;
    exp_t e;
    @(posedge clk);
    if (rst) begin
      m_div = 0; m_st = 0; mx = 0; my = 0;
    end else begin
      tk  = (m_div == 3);
      nst = m_st;
      case (m_st)
        0: if (en) nst = 1;
        1: if (!en) nst = 2;
        default: begin
          if (en) nst = 1;
          else if (tk && mx == HT - 1 && my == VT - 1) nst = 0;
        end
      endcase
      if (m_st != 0 && tk) begin
        mx++;
        if (mx == HT) begin
          mx = 0;
          my++;
          if (my == VT) my = 0;
        end
      end
      if (nst == 0) begin
        mx = 0; my = 0;
      end
      m_st  = nst;
      m_div = (m_div + 1) % 4;
    end
    #1;
    if (m_div == 3) begin
      e.cyc = cyc;
      e.obs = modelObs();
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int n);
    rst = r;
    en  = e;
    repeat (n) stepCycle();
  endtask

  // Full output comparison against the model, called away from the edge.
  task automatic checkOutput(input string name);
    obs_t want, act_v;
    logic want_tick;
    want      = modelObs();
    want_tick = (m_div == 3);
    act_v     = {x, y, hsync, vsync, video_on, frame_start, active};
    n_cmp++;
    if (act_v !== want || pixel_tick !== want_tick) begin
      n_bad++;
      $display("[TB] FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b act=%b tick=%b, required x=%0d y=%0d hs=%b vs=%b von=%b fs=%b act=%b tick=%b",
               name, x, y, hsync, vsync, video_on, frame_start, active, pixel_tick,
               want.x, want.y, want.hs, want.vs, want.von, want.fs, want.act, want_tick);
    end
  endtask

  task automatic checkValue(input string name, input int got_v, input int want_v);
    n_cmp++;
    if (got_v != want_v) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got_v, want_v);
    end
  endtask

  // Scoreboard monitor: pops one expectation per DUT pixel tick; an
  // expectation whose cycle has passed without a tick is a missed tick.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL missing_tick: got no PIXEL_TICK at cycle %0d, required one", sb[0].cyc);
      void'(sb.pop_front());
    end
    if (pixel_tick) begin
      n_cmp++;
      got = {x, y, hsync, vsync, video_on, frame_start, active};
      if (sb.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_tick: got PIXEL_TICK at cycle %0d, required none", cyc);
      end else begin
        head = sb.pop_front();
        if (head.cyc != cyc || got !== head.obs) begin
          n_bad++;
          $display("[TB] FAIL tick_outputs: cycle %0d got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b act=%b, required cycle %0d x=%0d y=%0d hs=%b vs=%b von=%b fs=%b act=%b",
                   cyc, x, y, hsync, vsync, video_on, frame_start, active,
                   head.cyc, head.obs.x, head.obs.y, head.obs.hs, head.obs.vs,
                   head.obs.von, head.obs.fs, head.obs.act);
        end
      end
      tick_cnt++;
      if (frame_start) begin
        if (fs_seen && !frame_done) begin
          frame_len  = tick_cnt - fs_tick;
          f_von      = acc_von;
          f_hs       = acc_hs;
          f_vs       = acc_vs;
          frame_done = 1;
        end
        fs_seen = 1;
        fs_tick = tick_cnt;
        acc_von = 0; acc_hs = 0; acc_vs = 0;
      end
      if (video_on)    acc_von++;
      if (hsync == ON) acc_hs++;
      if (vsync == ON) acc_vs++;
    end
  end

  initial begin
    $display("[TB] start, sync active level %b", ON);

    // reset, release, then idle ticks with ENABLE low
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 0);
    @(negedge clk);
    checkOutput("reset_state");
    applyStimulus(1'b0, 1'b0, 13);
    @(negedge clk);
    checkOutput("idle_running_divider");

    // run slightly more than one full frame
    applyStimulus(1'b0, 1'b1, 820);
    checkValue("frame_seen", int'(frame_done), 1);
    checkValue("frame_len_ticks", frame_len, 198);
    checkValue("video_on_ticks", f_von, 60);
    checkValue("hsync_ticks", f_hs, 33);
    checkValue("vsync_ticks", f_vs, 36);

    // drop ENABLE mid-frame and let it drain to IDLE
    for (int i = 0; i < 1000; i++) begin
      if (mx == 5 && my == 3) break;
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 0);
    for (int i = 0; i < 1000; i++) begin
      if (m_st == 0) break;
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 9);
    @(negedge clk);
    checkOutput("idle_after_drain");

    // drop and re-raise ENABLE before the frame ends
    applyStimulus(1'b0, 1'b1, 60);
    applyStimulus(1'b0, 1'b0, 40);
    applyStimulus(1'b0, 1'b1, 400);
    @(negedge clk);
    checkOutput("continuous_after_reraise");

    // re-raise ENABLE exactly on the frame-end tick while stopping
    applyStimulus(1'b0, 1'b0, 0);
    for (int i = 0; i < 1500; i++) begin
      if (m_st == 2 && mx == HT - 1 && my == VT - 1 && m_div == 3) break;
      stepCycle();
    end
    applyStimulus(1'b0, 1'b1, 4);
    @(negedge clk);
    checkOutput("reraise_at_frame_end");
    applyStimulus(1'b0, 1'b1, 8);

    // reset mid-frame while both syncs are active
    for (int i = 0; i < 1500; i++) begin
      if (mx == 13 && my == 7) break;
      stepCycle();
    end
    @(negedge clk);
    checkOutput("before_mid_reset");
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 0);
    @(negedge clk);
    checkOutput("reset_mid_frame");
    applyStimulus(1'b0, 1'b1, 24);

    applyStimulus(1'b0, 1'b0, 4);
    @(negedge clk);
    #1;
    checkValue("scoreboard_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
